// File: rtl/boa_csr_arbiter_if.sv
// boa_csr_arbiter_if: requester and CSR-bus signal bundle for boa_csr_arbiter.
// The slave modport is the arbiter's view; the master modport drives it.
interface boa_csr_arbiter_if;
    logic [1:0]  cur_priv;
    logic [1:0]  req;
    logic [11:0] req_addr0;
    logic [11:0] req_addr1;
    logic [1:0]  req_wmode0;
    logic [1:0]  req_wmode1;
    logic [31:0] req_wmask0;
    logic [31:0] req_wmask1;
    logic [1:0]  gnt;
    logic [1:0]  rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [11:0] csr_addr;
    logic        csr_we;
    logic [31:0] csr_wdata;
    logic        csr_exists;
    logic        csr_rdonly;
    logic [1:0]  csr_priv;
    logic [31:0] csr_rdata;

    modport slave (
        input  cur_priv, req,
        input  req_addr0, req_addr1,
        input  req_wmode0, req_wmode1,
        input  req_wmask0, req_wmask1,
        output gnt, rsp_valid, rsp_rdata, rsp_err,
        output csr_addr, csr_we, csr_wdata,
        input  csr_exists, csr_rdonly, csr_priv, csr_rdata
    );

    modport master (
        output cur_priv, req,
        output req_addr0, req_addr1,
        output req_wmode0, req_wmode1,
        output req_wmask0, req_wmask1,
        input  gnt, rsp_valid, rsp_rdata, rsp_err,
        input  csr_addr, csr_we, csr_wdata,
        output csr_exists, csr_rdonly, csr_priv, csr_rdata
    );
endinterface

// File: rtl/boa_csr_arbiter.sv
// boa_csr_arbiter: two-requester CSR bus arbiter with read/modify/write sequencing.
// Requester 1 (debug port) is only live when BOA_CSR_ARB_DEBUG_EN is defined.
module boa_csr_arbiter #(
    parameter int         FIXED_PRIO = 0,
    parameter logic [1:0] DBG_PRIV   = 2'b11
) (
    input  logic              clk,
    input  logic              rst,
    boa_csr_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        RESP
    } state_e;

    state_e      state_q, state_d;
    logic        id_q, id_d;
    logic        last_q, last_d;
    logic [11:0] addr_q, addr_d;
    logic [1:0]  wmode_q, wmode_d;
    logic [31:0] wmask_q, wmask_d;
    logic [1:0]  priv_q, priv_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [1:0]  req_eff;
    logic        win;
    logic [1:0]  gnt;
    logic [1:0]  rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        csr_we;
    logic [31:0] csr_wdata;

`ifdef BOA_CSR_ARB_DEBUG_EN
    assign req_eff = bus.req;
`else
    logic unused_req1;
    assign req_eff     = {1'b0, bus.req[0]};
    assign unused_req1 = bus.req[1];
`endif

    // last_q holds the id granted most recently; the other one wins a tie
    always_comb begin
        case (req_eff)
            2'b10:   win = 1'b1;
            2'b11:   win = (FIXED_PRIO != 0) ? 1'b0 : ~last_q;
            default: win = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        id_d      = id_q;
        last_d    = last_q;
        addr_d    = addr_q;
        wmode_d   = wmode_q;
        wmask_d   = wmask_q;
        priv_d    = priv_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        gnt       = 2'b00;
        rsp_valid = 2'b00;
        rsp_rdata = 32'h0;
        rsp_err   = 1'b0;
        csr_we    = 1'b0;
        csr_wdata = 32'h0;
        unique case (state_q)
            IDLE: begin
                if (!rst && req_eff != 2'b00) begin
                    gnt     = win ? 2'b10 : 2'b01;
                    id_d    = win;
                    last_d  = win;
                    addr_d  = win ? bus.req_addr1  : bus.req_addr0;
                    wmode_d = win ? bus.req_wmode1 : bus.req_wmode0;
                    wmask_d = win ? bus.req_wmask1 : bus.req_wmask0;
                    priv_d  = win ? DBG_PRIV       : bus.cur_priv;
                    state_d = READ;
                end
            end
            READ: begin
                rdata_d = bus.csr_rdata;
                err_d   = !bus.csr_exists
                        | (bus.csr_priv > priv_q)
                        | ((wmode_q != 2'b00) & bus.csr_rdonly);
                state_d = (wmode_q == 2'b00 || err_d) ? RESP : WRITE;
            end
            WRITE: begin
                csr_we = 1'b1;
                case (wmode_q)
                    2'b01:   csr_wdata = wmask_q;
                    2'b10:   csr_wdata = rdata_q | wmask_q;
                    2'b11:   csr_wdata = rdata_q & ~wmask_q;
                    default: csr_wdata = 32'h0;
                endcase
                state_d = RESP;
            end
            RESP: begin
                rsp_valid = id_q ? 2'b10 : 2'b01;
                rsp_err   = err_q;
                rsp_rdata = err_q ? 32'h0 : rdata_q;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            id_q    <= 1'b0;
            last_q  <= 1'b1;
            addr_q  <= 12'h0;
            wmode_q <= 2'b00;
            wmask_q <= 32'h0;
            priv_q  <= 2'b00;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            wmode_q <= wmode_d;
            wmask_q <= wmask_d;
            priv_q  <= priv_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign bus.gnt       = gnt;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_rdata = rsp_rdata;
    assign bus.rsp_err   = rsp_err;
    assign bus.csr_addr  = addr_q;
    assign bus.csr_we    = csr_we;
    assign bus.csr_wdata = csr_wdata;

endmodule

// File: tb/tb_boa_csr_arbiter.sv
// tb_boa_csr_arbiter: directed checks of boa_csr_arbiter against a small CSR file.
// Requester 1 scenarios follow BOA_CSR_ARB_DEBUG_EN.
module tb_boa_csr_arbiter;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    boa_csr_arbiter_if bus();

    boa_csr_arbiter #(
        .FIXED_PRIO (0),
        .DBG_PRIV   (2'b11)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // CSR file: exists, read-only, required priv, read value
    always_comb begin
        case (bus.csr_addr)
            12'h300: {bus.csr_exists, bus.csr_rdonly, bus.csr_priv, bus.csr_rdata}
                     = {1'b1, 1'b0, 2'd3, 32'h0000_1800};
            12'h341: {bus.csr_exists, bus.csr_rdonly, bus.csr_priv, bus.csr_rdata}
                     = {1'b1, 1'b0, 2'd3, 32'h8000_0104};
            12'hF14: {bus.csr_exists, bus.csr_rdonly, bus.csr_priv, bus.csr_rdata}
                     = {1'b1, 1'b1, 2'd3, 32'h0000_0005};
            12'hC00: {bus.csr_exists, bus.csr_rdonly, bus.csr_priv, bus.csr_rdata}
                     = {1'b1, 1'b1, 2'd0, 32'h0000_1234};
            default: {bus.csr_exists, bus.csr_rdonly, bus.csr_priv, bus.csr_rdata}
                     = {1'b0, 1'b0, 2'd0, 32'hDEAD_BEEF};
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic access(input bit id, input logic [1:0] priv,
                          input logic [11:0] addr, input logic [1:0] wm,
                          input logic [31:0] mask, input bit exp_err,
                          input logic [31:0] exp_rd, input logic [31:0] exp_wd);
        logic [1:0] oh;
        bit         wr;
        int         n;
        oh = id ? 2'b10 : 2'b01;
        wr = (wm != 2'b00) && !exp_err;
        @(posedge clk); #1;
        bus.cur_priv = priv;
        if (id) begin
            bus.req_addr1  = addr;
            bus.req_wmode1 = wm;
            bus.req_wmask1 = mask;
        end else begin
            bus.req_addr0  = addr;
            bus.req_wmode0 = wm;
            bus.req_wmask0 = mask;
        end
        bus.req = oh;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.gnt == 2'b00 && n < 4);
        check("gnt", {30'h0, bus.gnt}, {30'h0, oh});
        @(posedge clk); #1;
        bus.req = 2'b00;
        @(negedge clk);
        check("read_addr", {20'h0, bus.csr_addr}, {20'h0, addr});
        check("read_we_rsp", {29'h0, bus.csr_we, bus.rsp_valid}, 32'h0);
        if (wr) begin
            @(negedge clk);
            check("write_we", {31'h0, bus.csr_we}, 32'h1);
            check("write_data", bus.csr_wdata, exp_wd);
            check("write_addr", {20'h0, bus.csr_addr}, {20'h0, addr});
            check("write_rsp", {30'h0, bus.rsp_valid}, 32'h0);
        end
        @(negedge clk);
        check("rsp_valid", {30'h0, bus.rsp_valid}, {30'h0, oh});
        check("rsp_err", {31'h0, bus.rsp_err}, {31'h0, exp_err});
        check("rsp_rdata", bus.rsp_rdata, exp_rd);
        check("rsp_we", {31'h0, bus.csr_we}, 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  exp_g;
        logic [1:0]  exp_v;
        logic [31:0] exp_d;
        n_tests = 0;
        n_fail  = 0;
        rst            = 1'b1;
        bus.cur_priv   = 2'd3;
        bus.req        = 2'b01;
        bus.req_addr0  = 12'h300;
        bus.req_addr1  = 12'h300;
        bus.req_wmode0 = 2'b00;
        bus.req_wmode1 = 2'b00;
        bus.req_wmask0 = 32'h0;
        bus.req_wmask1 = 32'h0;
        repeat (2) @(negedge clk);
        check("rst_gnt", {30'h0, bus.gnt}, 32'h0);
        check("rst_rsp_valid", {30'h0, bus.rsp_valid}, 32'h0);
        check("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
        check("rst_rsp_err", {31'h0, bus.rsp_err}, 32'h0);
        check("rst_we", {31'h0, bus.csr_we}, 32'h0);
        check("rst_addr", {20'h0, bus.csr_addr}, 32'h0);
        check("rst_wdata", bus.csr_wdata, 32'h0);
        @(posedge clk); #1;
        rst     = 1'b0;
        bus.req = 2'b00;

        access(0, 2'd3, 12'h300, 2'b10, 32'h8, 0, 32'h1800, 32'h1808);
        access(0, 2'd0, 12'h341, 2'b00, 32'h0, 1, 32'h0, 32'h0);
        access(0, 2'd3, 12'hF14, 2'b01, 32'hFFFF, 1, 32'h0, 32'h0);
        access(0, 2'd3, 12'hF14, 2'b00, 32'h0, 0, 32'h5, 32'h0);
        access(0, 2'd3, 12'h341, 2'b11, 32'h4, 0, 32'h8000_0104, 32'h8000_0100);
        access(0, 2'd3, 12'h341, 2'b01, 32'h1234_5678, 0, 32'h8000_0104, 32'h1234_5678);
        access(0, 2'd3, 12'h7C0, 2'b00, 32'h0, 1, 32'h0, 32'h0);
        access(0, 2'd0, 12'hC00, 2'b00, 32'h0, 0, 32'h1234, 32'h0);

        // reset while a write access sits in READ
        @(posedge clk); #1;
        bus.cur_priv   = 2'd3;
        bus.req_addr0  = 12'h300;
        bus.req_wmode0 = 2'b01;
        bus.req_wmask0 = 32'hAAAA;
        bus.req        = 2'b01;
        @(negedge clk);
        check("abort_gnt", {30'h0, bus.gnt}, 32'h1);
        @(posedge clk); #1;
        bus.req = 2'b00;
        rst     = 1'b1;
        @(negedge clk);
        check("abort_read_we", {31'h0, bus.csr_we}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("abort_quiet", {29'h0, bus.csr_we, bus.rsp_valid}, 32'h0);
        end

`ifdef BOA_CSR_ARB_DEBUG_EN
        // both requesting: pointer was reset, so requester 0 opens
        @(posedge clk); #1;
        bus.cur_priv   = 2'd3;
        bus.req_addr0  = 12'hF14;
        bus.req_wmode0 = 2'b00;
        bus.req_addr1  = 12'hC00;
        bus.req_wmode1 = 2'b00;
        bus.req        = 2'b11;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            exp_g = 2'b00;
            exp_v = 2'b00;
            exp_d = 32'h0;
            if (k % 3 == 0) exp_g = ((k / 3) % 2 == 0) ? 2'b01 : 2'b10;
            if (k % 3 == 2) begin
                exp_v = (((k - 2) / 3) % 2 == 0) ? 2'b01 : 2'b10;
                exp_d = (exp_v == 2'b01) ? 32'h5 : 32'h1234;
            end
            check("rr_gnt", {30'h0, bus.gnt}, {30'h0, exp_g});
            check("rr_rsp_valid", {30'h0, bus.rsp_valid}, {30'h0, exp_v});
            check("rr_rsp_rdata", bus.rsp_rdata, exp_d);
        end
        @(posedge clk); #1;
        bus.req = 2'b00;
        access(1, 2'd0, 12'h341, 2'b00, 32'h0, 0, 32'h8000_0104, 32'h0);
        access(1, 2'd0, 12'h300, 2'b10, 32'h1, 0, 32'h1800, 32'h1801);
`else
        access(0, 2'd3, 12'hF14, 2'b00, 32'h0, 0, 32'h5, 32'h0);
        @(posedge clk); #1;
        bus.req_addr1  = 12'h300;
        bus.req_wmode1 = 2'b01;
        bus.req_wmask1 = 32'hFFFF_FFFF;
        bus.req        = 2'b10;
        repeat (10) begin
            @(negedge clk);
            check("dbg_off", {27'h0, bus.gnt, bus.rsp_valid, bus.csr_we}, 32'h0);
        end
        @(posedge clk); #1;
        bus.req = 2'b00;
`endif

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/boa_csr_arbiter.md
Name: boa_csr_arbiter

Overview:
- Shares the single zero-latency CSR access bus between two requesters: requester 0 is the pipeline CSR unit, requester 1 is the debug port.
- Sequences each access as a read cycle followed by an optional write cycle.
- Computes write data for write, set and clear modes, and checks existence, read-only and privilege.
- Returns the old CSR value, or an error, on a one-cycle response strobe.

Parameters:
- FIXED_PRIO, 0, 1 = requester 0 always wins a contest; 0 = round-robin.
- DBG_PRIV, 2'b11, effective privilege applied to requester 1 accesses.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- cur_priv  in  2  current hart privilege, used for requester 0.
- req  in  2  per-requester access request; must be held stable until gnt.
- req_addr0, req_addr1  in  12 each  CSR address.
- req_wmode0, req_wmode1  in  2 each  00 read-only, 01 write, 10 set, 11 clear.
- req_wmask0, req_wmask1  in  32 each  write value or mask.
- gnt  out  2  one-hot, one-cycle pulse; the request is latched on this cycle.
- rsp_valid  out  2  one-hot, one-cycle response strobe.
- rsp_rdata  out  32  CSR value read before any write; 0 when err.
- rsp_err  out  1  illegal access; valid with rsp_valid.
- csr_addr  out  12  CSR bus address.
- csr_we  out  1  CSR bus write enable.
- csr_wdata  out  32  CSR bus write data.
- csr_exists  in  1  CSR exists.
- csr_rdonly  in  1  CSR is read-only.
- csr_priv  in  2  required privilege.
- csr_rdata  in  32  CSR read data, combinational from csr_addr.

Behaviour:
- Reset values (next edge after rst high): state IDLE, gnt=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, csr_we=0, csr_addr=0, csr_wdata=0, last-grant pointer=1 (requester 0 wins the first contest).
- FSM states: IDLE, READ, WRITE, RESP.
- IDLE: if any req bit is set, pick a winner and pulse its gnt bit. Latch addr, wmode, wmask, requester id and effective privilege (cur_priv for requester 0, DBG_PRIV for requester 1). Next state READ. With no request, stay in IDLE.
- Arbitration with both requesting:
  - FIXED_PRIO=1: requester 0 wins.
  - FIXED_PRIO=0: the requester not granted last time wins.
  - A single requester always wins. Pointer updates on every grant.
- READ: csr_addr=latched addr, csr_we=0. Register csr_rdata. err = !csr_exists | (csr_priv > eff_priv) | (wmode!=00 & csr_rdonly).
  - wmode==00 or err: next state RESP.
  - Otherwise: next state WRITE.
- WRITE:
  - csr_addr held, csr_we=1 for exactly one cycle.
  - csr_wdata = wmask (01), rdata|wmask (10), or rdata&~wmask (11), using the rdata registered in READ.
  - Next state RESP.
- RESP: rsp_valid[id]=1 for one cycle. rsp_rdata = registered old value, or 0 if err. Next state IDLE. A new grant cannot occur in the same cycle.
- Latency, grant cycle = T:
  - read-only or error access: rsp at T+2.
  - write access: write at T+2, rsp at T+3.
  - Back-to-back accesses: next gnt at earliest T+3 or T+4.
- csr_we is never asserted on error. csr_we=0 in all states other than WRITE.
- req bits deasserted while the FSM is busy are ignored. A requester dropping req before gnt is never granted.
- rst mid-operation: abort. No write is issued or completed after the reset edge, no rsp is produced, and the pointer resets.

Optional Feature:
- Macro: BOA_CSR_ARB_DEBUG_EN.
- Defined: requester 1 is fully functional as described above.
- Undefined:
  - req[1] is ignored, gnt[1]=0 and rsp_valid[1]=0 constantly.
  - Requester 1 ports remain present but unused, and FIXED_PRIO is irrelevant.
  - Requester 0 timing is unchanged.

Test Plan:
1. Requester 0, cur_priv=3, addr 0x300 (exists, priv 3, rdata 0x0000_1800), wmode 10, wmask 0x8 -> gnt[0] at T; csr_we=1 with csr_wdata=0x0000_1808 at T+2; rsp_valid[0] at T+3 with rsp_rdata=0x1800, err=0.
2. Requester 0, cur_priv=0, addr 0x341 (priv 3), wmode 00 -> no csr_we; rsp at T+2 with err=1, rdata=0.
3. Write mode 01 to a read-only CSR 0xF14 -> err=1, csr_we never asserted. Same CSR with wmode 00 -> err=0, rsp_rdata=csr_rdata.
4. FIXED_PRIO=0, both requesting continuously with read-only accesses -> grants alternate 0,1,0,1, each 3 cycles apart. FIXED_PRIO=1 -> gnt[0] only.
5. Assert rst in the cycle the FSM is in READ of a write access -> csr_we stays 0, no rsp_valid; the next contest is won by requester 0.
6. Macro undefined: req=2'b10 held for 10 cycles -> gnt=0, rsp_valid=0, csr_we=0 throughout.
